nasti_buf_ch: RTL and testbench



---
 rtl/nasti_buf_ch_if.sv | 92 +++++++++
 rtl/nasti_buf_ch.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_nasti_buf_ch.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nasti_buf_ch_if.sv
`default_nettype none
// ============================================================================
// Module      : nasti_channel (interface)
// Description : NASTI (AXI4) five-channel bundle with master/slave modports.
// Revision    : 1.0 - initial release
// ============================================================================
interface nasti_channel #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic [3:0]              aw_qos;
  logic [3:0]              aw_region;
  logic [USER_WIDTH-1:0]   aw_user;
  logic                    aw_valid;
  logic                    aw_ready;

  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic [3:0]              ar_qos;
  logic [3:0]              ar_region;
  logic [USER_WIDTH-1:0]   ar_user;
  logic                    ar_valid;
  logic                    ar_ready;

  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic [USER_WIDTH-1:0]   w_user;
  logic                    w_valid;
  logic                    w_ready;

  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic [USER_WIDTH-1:0]   b_user;
  logic                    b_valid;
  logic                    b_ready;

  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface
`default_nettype wire

// File: rtl/nasti_buf_ch.sv
`default_nettype none
// ============================================================================
// Module      : nasti_buf_ch (with helper nasti_buf_fifo)
// Description : Per-channel configurable NASTI register slice / FIFO with
//               outstanding-transaction limits and an idle indication.
//               Define NASTI_BUF_CH_STATS_EN to expose occupancy, outstanding
//               counters and a stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================

// Count-based FIFO; ready depends only on registered occupancy.
module nasti_buf_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);
  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;
  logic             push, pop;

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rp_q];
  assign count     = count_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Next-state: payload write, pointer wrap at DEPTH, occupancy update.
  always_comb begin
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (push) begin
      mem_d[wp_q] = in_data;
      wp_d        = (wp_q == LAST_PTR) ? '0 : wp_q + PTR_W'(1);
    end
    if (pop) begin
      rp_d = (rp_q == LAST_PTR) ? '0 : rp_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
    end else begin
      count_q <= count_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
    end
  end

  // Payload storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

module nasti_buf_ch #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int AW_DEPTH   = 2,
  parameter int AR_DEPTH   = 2,
  parameter int W_DEPTH    = 2,
  parameter int B_DEPTH    = 2,
  parameter int R_DEPTH    = 2,
  parameter int MAX_WR_OUT = 0,
  parameter int MAX_RD_OUT = 0,
  localparam int AW_CW = (AW_DEPTH == 0) ? 1 : $clog2(AW_DEPTH + 1),
  localparam int AR_CW = (AR_DEPTH == 0) ? 1 : $clog2(AR_DEPTH + 1),
  localparam int W_CW  = (W_DEPTH  == 0) ? 1 : $clog2(W_DEPTH + 1),
  localparam int B_CW  = (B_DEPTH  == 0) ? 1 : $clog2(B_DEPTH + 1),
  localparam int R_CW  = (R_DEPTH  == 0) ? 1 : $clog2(R_DEPTH + 1),
  // An unlimited counter still needs a real width for idle tracking.
  localparam int WR_W  = (MAX_WR_OUT == 0) ? 16 : $clog2(MAX_WR_OUT + 1),
  localparam int RD_W  = (MAX_RD_OUT == 0) ? 16 : $clog2(MAX_RD_OUT + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  nasti_channel.slave   master,
  nasti_channel.master  slave,
  output logic          idle
`ifdef NASTI_BUF_CH_STATS_EN
  ,
  output logic [AW_CW-1:0] aw_cnt,
  output logic [AR_CW-1:0] ar_cnt,
  output logic [W_CW-1:0]  w_cnt,
  output logic [B_CW-1:0]  b_cnt,
  output logic [R_CW-1:0]  r_cnt,
  output logic [WR_W-1:0]  wr_out_cnt,
  output logic [RD_W-1:0]  rd_out_cnt,
  output logic [31:0]      stall_cycles
`endif
);
  localparam int AX_W = ID_WIDTH + ADDR_WIDTH + USER_WIDTH + 29;
  localparam int W_W  = DATA_WIDTH + DATA_WIDTH / 8 + 1 + USER_WIDTH;
  localparam int B_W  = ID_WIDTH + 2 + USER_WIDTH;
  localparam int R_W  = ID_WIDTH + DATA_WIDTH + 3 + USER_WIDTH;
  localparam logic [WR_W-1:0] WR_CAP = (MAX_WR_OUT == 0) ? {WR_W{1'b1}} : WR_W'(MAX_WR_OUT);
  localparam logic [RD_W-1:0] RD_CAP = (MAX_RD_OUT == 0) ? {RD_W{1'b1}} : RD_W'(MAX_RD_OUT);

  logic [AX_W-1:0]  aw_in, aw_out, ar_in, ar_out;
  logic [W_W-1:0]   w_in, w_out;
  logic [B_W-1:0]   b_in, b_out;
  logic [R_W-1:0]   r_in, r_out;
  logic             aw_in_valid, aw_in_ready, aw_out_valid;
  logic             ar_in_valid, ar_in_ready, ar_out_valid;
  logic             w_in_ready, w_out_valid;
  logic             b_in_ready, b_out_valid;
  logic             r_in_ready, r_out_valid;
  logic [AW_CW-1:0] aw_count;
  logic [AR_CW-1:0] ar_count;
  logic [W_CW-1:0]  w_count;
  logic [B_CW-1:0]  b_count;
  logic [R_CW-1:0]  r_count;
  logic [WR_W-1:0]  wr_out_q, wr_out_d;
  logic [RD_W-1:0]  rd_out_q, rd_out_d;
  logic             aw_block, ar_block, aw_hs, ar_hs, b_hs, r_last_hs;

  // Outstanding-limit gating; the limit is only active for a non-zero maximum.
  assign aw_block = (MAX_WR_OUT != 0) && (wr_out_q == WR_CAP);
  assign ar_block = (MAX_RD_OUT != 0) && (rd_out_q == RD_CAP);

  // Request-side packing (master -> slave).
  assign aw_in = {master.aw_id, master.aw_addr, master.aw_len, master.aw_size, master.aw_burst,
                  master.aw_lock, master.aw_cache, master.aw_prot, master.aw_qos,
                  master.aw_region, master.aw_user};
  assign ar_in = {master.ar_id, master.ar_addr, master.ar_len, master.ar_size, master.ar_burst,
                  master.ar_lock, master.ar_cache, master.ar_prot, master.ar_qos,
                  master.ar_region, master.ar_user};
  assign w_in  = {master.w_data, master.w_strb, master.w_last, master.w_user};
  assign aw_in_valid     = master.aw_valid && !aw_block;
  assign ar_in_valid     = master.ar_valid && !ar_block;
  assign master.aw_ready = aw_in_ready && !aw_block;
  assign master.ar_ready = ar_in_ready && !ar_block;
  assign master.w_ready  = w_in_ready;
  assign {slave.aw_id, slave.aw_addr, slave.aw_len, slave.aw_size, slave.aw_burst,
          slave.aw_lock, slave.aw_cache, slave.aw_prot, slave.aw_qos,
          slave.aw_region, slave.aw_user} = aw_out;
  assign {slave.ar_id, slave.ar_addr, slave.ar_len, slave.ar_size, slave.ar_burst,
          slave.ar_lock, slave.ar_cache, slave.ar_prot, slave.ar_qos,
          slave.ar_region, slave.ar_user} = ar_out;
  assign {slave.w_data, slave.w_strb, slave.w_last, slave.w_user} = w_out;
  assign slave.aw_valid = aw_out_valid;
  assign slave.ar_valid = ar_out_valid;
  assign slave.w_valid  = w_out_valid;

  // Response-side packing (slave -> master).
  assign b_in = {slave.b_id, slave.b_resp, slave.b_user};
  assign r_in = {slave.r_id, slave.r_data, slave.r_resp, slave.r_last, slave.r_user};
  assign slave.b_ready = b_in_ready;
  assign slave.r_ready = r_in_ready;
  assign {master.b_id, master.b_resp, master.b_user} = b_out;
  assign {master.r_id, master.r_data, master.r_resp, master.r_last, master.r_user} = r_out;
  assign master.b_valid = b_out_valid;
  assign master.r_valid = r_out_valid;

  generate
    if (AW_DEPTH == 0) begin : g_aw_pass
      assign aw_out       = aw_in;
      assign aw_out_valid = aw_in_valid;
      assign aw_in_ready  = slave.aw_ready;
      assign aw_count     = '0;
    end else begin : g_aw_fifo
      nasti_buf_fifo #(.WIDTH(AX_W), .DEPTH(AW_DEPTH), .CNT_W(AW_CW)) u_fifo (
        .clk(clk), .rstn(rstn), .in_valid(aw_in_valid), .in_ready(aw_in_ready),
        .in_data(aw_in), .out_valid(aw_out_valid), .out_ready(slave.aw_ready),
        .out_data(aw_out), .count(aw_count));
    end

    if (AR_DEPTH == 0) begin : g_ar_pass
      assign ar_out       = ar_in;
      assign ar_out_valid = ar_in_valid;
      assign ar_in_ready  = slave.ar_ready;
      assign ar_count     = '0;
    end else begin : g_ar_fifo
      nasti_buf_fifo #(.WIDTH(AX_W), .DEPTH(AR_DEPTH), .CNT_W(AR_CW)) u_fifo (
        .clk(clk), .rstn(rstn), .in_valid(ar_in_valid), .in_ready(ar_in_ready),
        .in_data(ar_in), .out_valid(ar_out_valid), .out_ready(slave.ar_ready),
        .out_data(ar_out), .count(ar_count));
    end

    if (W_DEPTH == 0) begin : g_w_pass
      assign w_out       = w_in;
      assign w_out_valid = master.w_valid;
      assign w_in_ready  = slave.w_ready;
      assign w_count     = '0;
    end else begin : g_w_fifo
      nasti_buf_fifo #(.WIDTH(W_W), .DEPTH(W_DEPTH), .CNT_W(W_CW)) u_fifo (
        .clk(clk), .rstn(rstn), .in_valid(master.w_valid), .in_ready(w_in_ready),
        .in_data(w_in), .out_valid(w_out_valid), .out_ready(slave.w_ready),
        .out_data(w_out), .count(w_count));
    end

    if (B_DEPTH == 0) begin : g_b_pass
      assign b_out       = b_in;
      assign b_out_valid = slave.b_valid;
      assign b_in_ready  = master.b_ready;
      assign b_count     = '0;
    end else begin : g_b_fifo
      nasti_buf_fifo #(.WIDTH(B_W), .DEPTH(B_DEPTH), .CNT_W(B_CW)) u_fifo (
        .clk(clk), .rstn(rstn), .in_valid(slave.b_valid), .in_ready(b_in_ready),
        .in_data(b_in), .out_valid(b_out_valid), .out_ready(master.b_ready),
        .out_data(b_out), .count(b_count));
    end

    if (R_DEPTH == 0) begin : g_r_pass
      assign r_out       = r_in;
      assign r_out_valid = slave.r_valid;
      assign r_in_ready  = master.r_ready;
      assign r_count     = '0;
    end else begin : g_r_fifo
      nasti_buf_fifo #(.WIDTH(R_W), .DEPTH(R_DEPTH), .CNT_W(R_CW)) u_fifo (
        .clk(clk), .rstn(rstn), .in_valid(slave.r_valid), .in_ready(r_in_ready),
        .in_data(r_in), .out_valid(r_out_valid), .out_ready(master.r_ready),
        .out_data(r_out), .count(r_count));
    end
  endgenerate

  // Outstanding transactions are counted at the master-side handshakes.
  assign aw_hs     = master.aw_valid && master.aw_ready;
  assign ar_hs     = master.ar_valid && master.ar_ready;
  assign b_hs      = master.b_valid && master.b_ready;
  assign r_last_hs = master.r_valid && master.r_ready && master.r_last;

  // Saturating up/down counters; simultaneous issue and completion cancel.
  always_comb begin
    wr_out_d = wr_out_q;
    rd_out_d = rd_out_q;
    if (aw_hs && !b_hs && (wr_out_q != WR_CAP)) begin
      wr_out_d = wr_out_q + WR_W'(1);
    end else if (b_hs && !aw_hs && (wr_out_q != '0)) begin
      wr_out_d = wr_out_q - WR_W'(1);
    end
    if (ar_hs && !r_last_hs && (rd_out_q != RD_CAP)) begin
      rd_out_d = rd_out_q + RD_W'(1);
    end else if (r_last_hs && !ar_hs && (rd_out_q != '0)) begin
      rd_out_d = rd_out_q - RD_W'(1);
    end
  end

  // Outstanding counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_out_q <= '0;
      rd_out_q <= '0;
    end else begin
      wr_out_q <= wr_out_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign idle = (aw_count == '0) && (ar_count == '0) && (w_count == '0) &&
                (b_count == '0) && (r_count == '0) &&
                (wr_out_q == '0) && (rd_out_q == '0);

`ifdef NASTI_BUF_CH_STATS_EN
  logic [31:0] stall_q, stall_d;
  logic        any_stall;

  assign any_stall = (master.aw_valid && !master.aw_ready) ||
                     (master.ar_valid && !master.ar_ready) ||
                     (master.w_valid  && !master.w_ready)  ||
                     (master.b_valid  && !master.b_ready)  ||
                     (master.r_valid  && !master.r_ready);

  // Wrapping count of cycles with any master-side channel stalled.
  always_comb begin
    stall_d = stall_q;
    if (any_stall) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign aw_cnt       = aw_count;
  assign ar_cnt       = ar_count;
  assign w_cnt        = w_count;
  assign b_cnt        = b_count;
  assign r_cnt        = r_count;
  assign wr_out_cnt   = wr_out_q;
  assign rd_out_cnt   = rd_out_q;
  assign stall_cycles = stall_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_nasti_buf_ch.sv
`default_nettype none
// ============================================================================
// Module      : tb_nasti_buf_ch
// Description : Directed self-checking bench for nasti_buf_ch
//               (AW=3, AR=2, W=2, B/R pass-through, MAX_RD_OUT=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nasti_buf_ch;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic idle;
  int   checks = 0;
  int   errors = 0;

  nasti_channel #(.ID_WIDTH(1), .ADDR_WIDTH(8), .DATA_WIDTH(8), .USER_WIDTH(1)) m_if ();
  nasti_channel #(.ID_WIDTH(1), .ADDR_WIDTH(8), .DATA_WIDTH(8), .USER_WIDTH(1)) s_if ();

`ifdef NASTI_BUF_CH_STATS_EN
  logic [1:0]  aw_cnt, ar_cnt, w_cnt;
  logic        b_cnt, r_cnt;
  logic [15:0] wr_out_cnt;
  logic [1:0]  rd_out_cnt;
  logic [31:0] stall_cycles;
`endif

  nasti_buf_ch #(
    .ID_WIDTH(1), .ADDR_WIDTH(8), .DATA_WIDTH(8), .USER_WIDTH(1),
    .AW_DEPTH(3), .AR_DEPTH(2), .W_DEPTH(2), .B_DEPTH(0), .R_DEPTH(0),
    .MAX_WR_OUT(0), .MAX_RD_OUT(2)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .master(m_if),
    .slave(s_if),
    .idle(idle)
`ifdef NASTI_BUF_CH_STATS_EN
    ,
    .aw_cnt(aw_cnt), .ar_cnt(ar_cnt), .w_cnt(w_cnt), .b_cnt(b_cnt), .r_cnt(r_cnt),
    .wr_out_cnt(wr_out_cnt), .rd_out_cnt(rd_out_cnt), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_addr [8];
    logic [7:0] e;
    int         k;
    logic       hs;

    exp_addr = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00};

    // Master-driven fields
    m_if.aw_id = '0; m_if.aw_addr = '0; m_if.aw_len = '0; m_if.aw_size = '0;
    m_if.aw_burst = '0; m_if.aw_lock = '0; m_if.aw_cache = '0; m_if.aw_prot = '0;
    m_if.aw_qos = '0; m_if.aw_region = '0; m_if.aw_user = '0; m_if.aw_valid = 1'b0;
    m_if.ar_id = '0; m_if.ar_addr = '0; m_if.ar_len = '0; m_if.ar_size = '0;
    m_if.ar_burst = '0; m_if.ar_lock = '0; m_if.ar_cache = '0; m_if.ar_prot = '0;
    m_if.ar_qos = '0; m_if.ar_region = '0; m_if.ar_user = '0; m_if.ar_valid = 1'b0;
    m_if.w_data = '0; m_if.w_strb = '0; m_if.w_last = 1'b0; m_if.w_user = '0;
    m_if.w_valid = 1'b0; m_if.b_ready = 1'b0; m_if.r_ready = 1'b0;
    // Slave-driven fields
    s_if.aw_ready = 1'b0; s_if.ar_ready = 1'b0; s_if.w_ready = 1'b0;
    s_if.b_id = '0; s_if.b_resp = '0; s_if.b_user = '0; s_if.b_valid = 1'b0;
    s_if.r_id = '0; s_if.r_data = '0; s_if.r_resp = '0; s_if.r_last = 1'b0;
    s_if.r_user = '0; s_if.r_valid = 1'b0;

    // Reset and release
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    #1;
    check_eq("rst_s_aw_valid", s_if.aw_valid, 0);
    check_eq("rst_s_ar_valid", s_if.ar_valid, 0);
    check_eq("rst_s_w_valid",  s_if.w_valid, 0);
    check_eq("rst_m_b_valid",  m_if.b_valid, 0);
    check_eq("rst_idle",       idle, 1);
    check_eq("rst_m_aw_ready", m_if.aw_ready, 1);
    check_eq("rst_m_ar_ready", m_if.ar_ready, 1);
    check_eq("rst_m_w_ready",  m_if.w_ready, 1);

    // 16 back-to-back W beats through the 2-deep W FIFO
    tick();
    s_if.w_ready = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      if (c == 0) begin
        check_eq("w_pre_valid", s_if.w_valid, 0);
      end else begin
        e = 8'(c - 1);
        check_eq("w_beat", {s_if.w_valid, s_if.w_last, s_if.w_strb, s_if.w_data},
                 {1'b1, (c == 16), ~e[0], e});
      end
      if (c < 16) begin
        e = 8'(c);
        m_if.w_valid = 1'b1;
        m_if.w_data  = e;
        m_if.w_strb  = ~e[0];
        m_if.w_last  = (c == 15);
        #1;
        check_eq("w_push_ready", m_if.w_ready, 1);
      end else begin
        m_if.w_valid = 1'b0;
        m_if.w_last  = 1'b0;
      end
      tick();
    end
    check_eq("w_drained", s_if.w_valid, 0);

    // AW FIFO depth 3 fills, 4th stalls
    s_if.aw_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_if.aw_valid = 1'b1;
      m_if.aw_addr  = exp_addr[i];
      #1;
      check_eq("aw_fill_ready", m_if.aw_ready, (i < 3));
      tick();
    end
    check_eq("aw_full_ready", m_if.aw_ready, 0);
    s_if.aw_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      hs = m_if.aw_valid && m_if.aw_ready;
      if (s_if.aw_valid) begin
        check_eq("aw_order", s_if.aw_addr, exp_addr[k]);
        if (k < 7) k++;
      end
      tick();
      if (hs) m_if.aw_valid = 1'b0;
    end
    check_eq("aw_emitted", k, 4);
    check_eq("idle_wr_out", idle, 0);

    // B pass-through; 4 returns plus one spurious that must not underflow
    s_if.b_valid = 1'b1; s_if.b_id = 1'b1; s_if.b_resp = 2'd2; s_if.b_user = 1'b1;
    m_if.b_ready = 1'b0;
    #1;
    check_eq("b_pass_valid",  m_if.b_valid, 1);
    check_eq("b_pass_fields", {m_if.b_id, m_if.b_resp, m_if.b_user}, 4'b1101);
    check_eq("b_pass_ready0", s_if.b_ready, 0);
    m_if.b_ready = 1'b1;
    #1;
    check_eq("b_pass_ready1", s_if.b_ready, 1);
    repeat (5) tick();
    s_if.b_valid = 1'b0;
    m_if.b_ready = 1'b0;
    #1;
    check_eq("idle_after_b", idle, 1);

    // Read outstanding limit of 2
    s_if.ar_ready = 1'b1;
    m_if.r_ready  = 1'b1;
    m_if.ar_valid = 1'b1; m_if.ar_addr = 8'hA1; m_if.ar_len = 8'd1;
    #1;
    check_eq("ar1_ready", m_if.ar_ready, 1);
    tick();
    m_if.ar_addr = 8'hA2;
    #1;
    check_eq("ar1_out", {s_if.ar_valid, s_if.ar_addr}, {1'b1, 8'hA1});
    check_eq("ar2_ready", m_if.ar_ready, 1);
    tick();
    m_if.ar_addr = 8'hA3;
    #1;
    check_eq("ar3_held", m_if.ar_ready, 0);
    tick();
    check_eq("ar3_still_held", m_if.ar_ready, 0);
    s_if.r_valid = 1'b1; s_if.r_id = 1'b0; s_if.r_data = 8'h5A; s_if.r_resp = 2'd1;
    s_if.r_last = 1'b0; s_if.r_user = 1'b1;
    #1;
    check_eq("r_pass", {m_if.r_valid, m_if.r_id, m_if.r_data, m_if.r_resp, m_if.r_last, m_if.r_user},
             {1'b1, 1'b0, 8'h5A, 2'd1, 1'b0, 1'b1});
    check_eq("r_pass_ready", s_if.r_ready, 1);
    tick();
    check_eq("ar3_after_nonlast", m_if.ar_ready, 0);
    s_if.r_last = 1'b1; s_if.r_data = 8'hC3;
    #1;
    check_eq("r_pass_last", {m_if.r_last, m_if.r_data}, {1'b1, 8'hC3});
    tick();
    s_if.r_valid = 1'b0;
    #1;
    check_eq("ar3_ready_after_last", m_if.ar_ready, 1);
    tick();
    m_if.ar_valid = 1'b0;
    #1;
    check_eq("ar_limit_again", m_if.ar_ready, 0);
    check_eq("idle_rd_busy", idle, 0);
    s_if.r_valid = 1'b1;
    repeat (2) tick();
    s_if.r_valid = 1'b0;
    s_if.r_last  = 1'b0;
    #1;
    check_eq("idle_after_r", idle, 1);
    check_eq("ar_ready_after_r", m_if.ar_ready, 1);

    // Fill W FIFO, then reset mid-burst
    s_if.w_ready  = 1'b0;
    s_if.aw_ready = 1'b0;
    m_if.aw_valid = 1'b1; m_if.aw_addr = 8'h55;
    for (int i = 0; i < 2; i++) begin
      m_if.w_valid = 1'b1;
      m_if.w_data  = 8'(8'hE0 + i);
      #1;
      check_eq("w_fill_ready", m_if.w_ready, 1);
      tick();
      m_if.aw_valid = 1'b0;
    end
    check_eq("w_full_ready", m_if.w_ready, 0);
    check_eq("w_full_valid", s_if.w_valid, 1);
    check_eq("idle_busy", idle, 0);
    #2;
    rstn = 1'b0;
    m_if.w_valid = 1'b0;
    #1;
    check_eq("rst_mid_w_valid", s_if.w_valid, 0);
    check_eq("rst_mid_aw_valid", s_if.aw_valid, 0);
    check_eq("rst_mid_idle", idle, 1);
    @(posedge clk);
    #3 rstn = 1'b1;
    tick();
    check_eq("post_rst_w_valid", s_if.w_valid, 0);
    check_eq("post_rst_w_ready", m_if.w_ready, 1);
    check_eq("post_rst_idle", idle, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
